fifo_read_ctrl: RTL

//  Parametrised read-side controller for the synchronous FIFO: read pointer with wrap bit,

---
 rtl/fifo_read_ctrl.sv | 57 +++++
 1 files changed

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller for a synchronous FIFO (pointer, flags, read-valid, flush, underflow)
// Ports: clk, rst_n (sync, active-low); rd, flush, ufl_clr, wptr in;
//   rptr, raddr, fifo_rd, rd_valid, fifo_empty, almost_empty, count, underflow out.
// Define FIFO_RD_GRAY_EN to add the registered rptr_gray output for CDC to a remote writer.
module fifo_read_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              flush,
  input  logic              ufl_clr,
  input  logic [ADDR_W:0]   wptr,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W-1:0] raddr,
  output logic              fifo_rd,
  output logic              rd_valid,
  output logic              fifo_empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              underflow
`ifdef FIFO_RD_GRAY_EN
  ,
  output logic [ADDR_W:0]   rptr_gray
`endif
);
  localparam logic [ADDR_W:0] AE = AE_THRESH[ADDR_W:0];
  logic [ADDR_W:0] rptr_nxt;
  always_comb begin
    fifo_empty   = wptr == rptr;
    count        = wptr - rptr;
    almost_empty = count <= AE;
    raddr        = rptr[ADDR_W-1:0];
    fifo_rd      = rd & ~fifo_empty & ~flush;
    rptr_nxt     = flush ? wptr : fifo_rd ? rptr + 1'b1 : rptr;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr      <= '0;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rptr      <= rptr_nxt;
      rd_valid  <= fifo_rd;
      // set wins over clear; a read dropped by flush is not an underflow
      underflow <= (rd & fifo_empty & ~flush) | (underflow & ~ufl_clr);
    end
  end
`ifdef FIFO_RD_GRAY_EN
  // encoded from the next pointer so the gray copy moves on the same edge as rptr
  always_ff @(posedge clk) begin
    if (!rst_n) rptr_gray <= '0;
    else rptr_gray <= rptr_nxt ^ (rptr_nxt >> 1);
  end
`endif
endmodule
